// File: rtl/freqsel_pkg.sv
// Shared types, default frequency table and divider-count helper for freq_select_gen.
package freqsel_pkg;

    localparam int MAX_MODES = 16;

    // Entries beyond the eighth repeat the top frequency so larger NUM_MODES still elaborate.
    localparam longint DEF_FREQ_HZ [MAX_MODES] = '{
        64'd1_000,     64'd5_000,     64'd10_000,    64'd50_000,
        64'd100_000,   64'd500_000,   64'd1_000_000, 64'd2_000_000,
        64'd2_000_000, 64'd2_000_000, 64'd2_000_000, 64'd2_000_000,
        64'd2_000_000, 64'd2_000_000, 64'd2_000_000, 64'd2_000_000
    };

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } deb_state_t;

    // Half-period count, truncated, never below 1.
    function automatic longint freq2count(longint clk_hz, longint f);
        longint c;
        c = (f > 0) ? clk_hz / (2 * f) : clk_hz;
        return (c < 1) ? 64'sd1 : c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debouncer FSM for one active-low button; emits a one-cycle press pulse.
// Optional auto-repeat while held is enabled by FREQSEL_AUTOREPEAT_EN.
module btn_debounce
    import freqsel_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          lvl;
    deb_state_t    state;
    logic [CW-1:0] cnt;

    assign lvl = sync_q[1];

`ifdef FREQSEL_AUTOREPEAT_EN
    localparam int FIRST_CYC = 50 * DEBOUNCE_CYC;
    localparam int RPT_CYC   = 10 * DEBOUNCE_CYC;
    localparam int RW        = $clog2(FIRST_CYC + 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;
    logic [RW-1:0] rpt_last;

    assign rpt_last = rpt_first ? RW'(FIRST_CYC - 1) : RW'(RPT_CYC - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            press     <= 1'b0;
`ifdef FREQSEL_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
        end else begin
            sync_q <= {sync_q[0], btn_n};
            press  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!lvl) begin
                        state <= DEB_PRESS;
                        cnt   <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (lvl) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state     <= HELD;
                        cnt       <= '0;
                        press     <= 1'b1;
`ifdef FREQSEL_AUTOREPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (lvl) begin
                        state <= DEB_REL;
                        cnt   <= '0;
                    end
`ifdef FREQSEL_AUTOREPEAT_EN
                    // First repeat after a long hold, then at the shorter rate.
                    else if (rpt_cnt == rpt_last) begin
                        press     <= 1'b1;
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b0;
                    end else begin
                        rpt_cnt <= rpt_cnt + RW'(1);
                    end
`endif
                end
                DEB_REL: begin
                    if (!lvl) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/freq_select_gen.sv
// Button-driven frequency selector: steps a mode table and applies the new divider count
// only at a waveform period boundary. Define FREQSEL_AUTOREPEAT_EN for held-button auto-repeat.
module freq_select_gen
    import freqsel_pkg::*;
#(
    parameter longint CLK_HZ       = 50_000_000,
    parameter int     NUM_MODES    = 8,
    parameter int     CNT_W        = 28,
    parameter int     DEBOUNCE_CYC = 500_000,
    parameter int     WRAP         = 1,
    parameter int     INIT_MODE    = 0,
    localparam int    MODE_W       = $clog2(NUM_MODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_up_n,
    input  logic              sel_dn_n,
    input  logic              period_done,
    output logic [MODE_W-1:0] mode,
    output logic [CNT_W-1:0]  count,
    output logic              count_upd,
    output logic              pending
);

    localparam logic [CNT_W-1:0] INIT_COUNT = CNT_W'(freq2count(CLK_HZ, DEF_FREQ_HZ[INIT_MODE]));

    if (NUM_MODES < 2 || NUM_MODES > MAX_MODES) begin : g_bad_modes
        $error("freq_select_gen: NUM_MODES out of range");
    end
    if (INIT_MODE < 0 || INIT_MODE >= NUM_MODES) begin : g_bad_init
        $error("freq_select_gen: INIT_MODE out of range");
    end

    logic [CNT_W-1:0] cnt_tab [NUM_MODES];

    for (genvar i = 0; i < NUM_MODES; i++) begin : g_tab
        localparam longint C = freq2count(CLK_HZ, DEF_FREQ_HZ[i]);
        if (C >= (64'sd1 <<< CNT_W)) begin : g_ovf
            $error("freq_select_gen: table entry overflows CNT_W");
        end
        assign cnt_tab[i] = CNT_W'(C);
    end

    // Index 0 = up, 1 = down.
    logic [1:0] btn_n;
    logic [1:0] press;

    assign btn_n = {sel_dn_n, sel_up_n};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .btn_n (btn_n[b]),
            .press (press[b])
        );
    end

    logic [MODE_W-1:0] mode_nxt;
    logic              apply;

    always_comb begin
        mode_nxt = mode;
        if (press[0] && !press[1]) begin
            if (mode == MODE_W'(NUM_MODES - 1))
                mode_nxt = (WRAP != 0) ? '0 : mode;
            else
                mode_nxt = mode + MODE_W'(1);
        end else if (press[1] && !press[0]) begin
            if (mode == '0)
                mode_nxt = (WRAP != 0) ? MODE_W'(NUM_MODES - 1) : mode;
            else
                mode_nxt = mode - MODE_W'(1);
        end
    end

    assign apply = period_done && pending;

    // Apply uses the pre-step mode; a coincident step re-arms pending for the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= MODE_W'(INIT_MODE);
            count     <= INIT_COUNT;
            count_upd <= 1'b0;
            pending   <= 1'b0;
        end else begin
            count_upd <= apply;
            if (apply)
                count <= cnt_tab[mode];
            mode <= mode_nxt;
            if (mode_nxt != mode)
                pending <= 1'b1;
            else if (apply)
                pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_select_gen.sv
// Scoreboard bench for freq_select_gen: a wrapping and a saturating instance share stimulus.
module tb_freq_select_gen;

    logic        clk;
    logic        rst;
    logic        sel_up_n;
    logic        sel_dn_n;
    logic        period_done;
    logic [2:0]  mode_w, mode_s;
    logic [27:0] count_w, count_s;
    logic        upd_w, upd_s;
    logic        pend_w, pend_s;

    int checks = 0;
    int failures = 0;

    int tab [8] = '{25000, 5000, 2500, 500, 250, 50, 25, 12};

    int exp_q [$];
    int exp_qs [$];
    int exp_mode, exp_pend, exp_cnt;
    int exp_mode_s, exp_pend_s, exp_cnt_s;
    int pop_w, pop_s;

    freq_select_gen #(.DEBOUNCE_CYC(16), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .sel_up_n(sel_up_n), .sel_dn_n(sel_dn_n),
        .period_done(period_done), .mode(mode_w), .count(count_w),
        .count_upd(upd_w), .pending(pend_w)
    );

    freq_select_gen #(.DEBOUNCE_CYC(16), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .sel_up_n(sel_up_n), .sel_dn_n(sel_dn_n),
        .period_done(period_done), .mode(mode_s), .count(count_s),
        .count_upd(upd_s), .pending(pend_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Every count_upd pulse must match the oldest scheduled apply.
    always @(negedge clk) begin
        if (upd_w === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL upd_wrap: unexpected count_upd, count=%0d", count_w);
            end else begin
                pop_w = exp_q.pop_front();
                if (count_w !== 28'(pop_w)) begin
                    failures++;
                    $display("FAIL upd_wrap: count=%0d, want %0d", count_w, pop_w);
                end
            end
        end
        if (upd_s === 1'b1) begin
            checks++;
            if (exp_qs.size() == 0) begin
                failures++;
                $display("FAIL upd_sat: unexpected count_upd, count=%0d", count_s);
            end else begin
                pop_s = exp_qs.pop_front();
                if (count_s !== 28'(pop_s)) begin
                    failures++;
                    $display("FAIL upd_sat: count=%0d, want %0d", count_s, pop_s);
                end
            end
        end
    end

    function automatic int step(int m, bit up, bit dn, bit wrap);
        if (up && !dn) return (m == 7) ? (wrap ? 0 : 7) : m + 1;
        if (dn && !up) return (m == 0) ? (wrap ? 7 : 0) : m - 1;
        return m;
    endfunction

    // Model of one period_done cycle: schedule the expected count for each instance.
    task automatic model_pd();
        if (exp_pend != 0) begin
            exp_q.push_back(tab[exp_mode]);
            exp_cnt  = tab[exp_mode];
            exp_pend = 0;
        end
        if (exp_pend_s != 0) begin
            exp_qs.push_back(tab[exp_mode_s]);
            exp_cnt_s  = tab[exp_mode_s];
            exp_pend_s = 0;
        end
    endtask

    task automatic pulse_pd();
        period_done = 1'b1;
        model_pd();
        @(posedge clk); #1;
        period_done = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    // Press event appears 19 edges after the raw edge is driven; pd can coincide with it.
    task automatic press(input bit up, input bit dn, input bit with_pd);
        int nm;
        if (up) sel_up_n = 1'b0;
        if (dn) sel_dn_n = 1'b0;
        repeat (19) @(posedge clk); #1;
        if (with_pd) begin
            period_done = 1'b1;
            model_pd();
        end
        @(posedge clk); #1;
        period_done = 1'b0;
        nm = step(exp_mode, up, dn, 1'b1);
        if (nm != exp_mode) exp_pend = 1;
        exp_mode = nm;
        nm = step(exp_mode_s, up, dn, 1'b0);
        if (nm != exp_mode_s) exp_pend_s = 1;
        exp_mode_s = nm;
        sel_up_n = 1'b1;
        sel_dn_n = 1'b1;
        repeat (22) @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel_up_n = 1'b1; sel_dn_n = 1'b1; period_done = 1'b0;
        exp_mode = 0; exp_pend = 0; exp_cnt = 25000;
        exp_mode_s = 0; exp_pend_s = 0; exp_cnt_s = 25000;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({mode_w, pend_w, upd_w, count_w} !== {3'd0, 1'b0, 1'b0, 28'd25000}) begin
            failures++;
            $display("FAIL reset_wrap: mode=%0d pend=%0d upd=%0d count=%0d, want 0 0 0 25000",
                     mode_w, pend_w, upd_w, count_w);
        end
        checks++;
        if ({mode_s, pend_s, upd_s, count_s} !== {3'd0, 1'b0, 1'b0, 28'd25000}) begin
            failures++;
            $display("FAIL reset_sat: mode=%0d pend=%0d upd=%0d count=%0d, want 0 0 0 25000",
                     mode_s, pend_s, upd_s, count_s);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if ({mode_w, pend_w, count_w} !== {3'(exp_mode), 1'b1, 28'd25000}) begin
            failures++;
            $display("FAIL basic_pending: mode=%0d pend=%0d count=%0d, want %0d 1 25000",
                     mode_w, pend_w, count_w, exp_mode);
        end
        pulse_pd();
        checks++;
        if ({mode_w, pend_w, upd_w, count_w} !== {3'd1, 1'b0, 1'b0, 28'd5000}) begin
            failures++;
            $display("FAIL basic_apply: mode=%0d pend=%0d upd=%0d count=%0d, want 1 0 0 5000",
                     mode_w, pend_w, upd_w, count_w);
        end
    endtask

    task automatic test_pd_idle();
        pulse_pd();
        checks++;
        if ({mode_w, pend_w, count_w} !== {3'(exp_mode), 1'b0, 28'(exp_cnt)}) begin
            failures++;
            $display("FAIL pd_idle: mode=%0d pend=%0d count=%0d, want %0d 0 %0d",
                     mode_w, pend_w, count_w, exp_mode, exp_cnt);
        end
    endtask

    task automatic test_bounce();
        sel_up_n = 1'b0; repeat (10) @(posedge clk); #1;
        sel_up_n = 1'b1; repeat (2)  @(posedge clk); #1;
        sel_up_n = 1'b0; repeat (10) @(posedge clk); #1;
        sel_up_n = 1'b1; repeat (25) @(posedge clk); #1;
        checks++;
        if ({mode_w, pend_w} !== {3'(exp_mode), 1'b0}) begin
            failures++;
            $display("FAIL bounce_reject: mode=%0d pend=%0d, want %0d 0", mode_w, pend_w, exp_mode);
        end
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if ({mode_w, pend_w} !== {3'd2, 1'b1}) begin
            failures++;
            $display("FAIL bounce_accept: mode=%0d pend=%0d, want 2 1", mode_w, pend_w);
        end
        pulse_pd();
    endtask

    task automatic test_multi();
        repeat (3) press(1'b1, 1'b0, 1'b0);
        checks++;
        if ({mode_w, pend_w, count_w} !== {3'd5, 1'b1, 28'd2500}) begin
            failures++;
            $display("FAIL multi_hold: mode=%0d pend=%0d count=%0d, want 5 1 2500",
                     mode_w, pend_w, count_w);
        end
        press(1'b1, 1'b0, 1'b1);
        checks++;
        if ({mode_w, pend_w, count_w} !== {3'd6, 1'b1, 28'd50}) begin
            failures++;
            $display("FAIL multi_coincide: mode=%0d pend=%0d count=%0d, want 6 1 50",
                     mode_w, pend_w, count_w);
        end
        pulse_pd();
        checks++;
        if ({mode_w, pend_w, count_w} !== {3'd6, 1'b0, 28'd25}) begin
            failures++;
            $display("FAIL multi_final: mode=%0d pend=%0d count=%0d, want 6 0 25",
                     mode_w, pend_w, count_w);
        end
    endtask

    task automatic test_simul();
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if ({mode_w, pend_w, count_w} !== {3'd6, 1'b0, 28'd25}) begin
            failures++;
            $display("FAIL simul: mode=%0d pend=%0d count=%0d, want 6 0 25", mode_w, pend_w, count_w);
        end
    endtask

    task automatic test_wrap();
        press(1'b1, 1'b0, 1'b0);
        pulse_pd();
        checks++;
        if ({mode_w, count_w, mode_s, count_s} !== {3'd7, 28'd12, 3'd7, 28'd12}) begin
            failures++;
            $display("FAIL top_mode: wrap %0d/%0d sat %0d/%0d, want 7/12 7/12",
                     mode_w, count_w, mode_s, count_s);
        end
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if ({mode_w, pend_w} !== {3'd0, 1'b1}) begin
            failures++;
            $display("FAIL wrap_up: mode=%0d pend=%0d, want 0 1", mode_w, pend_w);
        end
        checks++;
        if ({mode_s, pend_s, count_s} !== {3'd7, 1'b0, 28'd12}) begin
            failures++;
            $display("FAIL sat_up: mode=%0d pend=%0d count=%0d, want 7 0 12", mode_s, pend_s, count_s);
        end
        pulse_pd();
        checks++;
        if ({count_w, count_s} !== {28'd25000, 28'd12}) begin
            failures++;
            $display("FAIL wrap_apply: wrap count=%0d sat count=%0d, want 25000 12", count_w, count_s);
        end
        press(1'b0, 1'b1, 1'b0);
        pulse_pd();
        checks++;
        if ({mode_w, count_w, mode_s, count_s} !== {3'd7, 28'd12, 3'd6, 28'd25}) begin
            failures++;
            $display("FAIL wrap_dn: wrap %0d/%0d sat %0d/%0d, want 7/12 6/25",
                     mode_w, count_w, mode_s, count_s);
        end
    endtask

    task automatic test_rst_deb();
        sel_up_n = 1'b0;
        repeat (8) @(posedge clk); #1;
        rst = 1'b1;
        sel_up_n = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_mode = 0; exp_pend = 0; exp_cnt = 25000;
        exp_mode_s = 0; exp_pend_s = 0; exp_cnt_s = 25000;
        repeat (30) @(posedge clk); #1;
        checks++;
        if ({mode_w, pend_w, count_w, mode_s, pend_s, count_s} !==
            {3'd0, 1'b0, 28'd25000, 3'd0, 1'b0, 28'd25000}) begin
            failures++;
            $display("FAIL rst_deb: wrap %0d/%0d/%0d sat %0d/%0d/%0d, want 0/0/25000 both",
                     mode_w, pend_w, count_w, mode_s, pend_s, count_s);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pd_idle();
        test_bounce();
        test_multi();
        test_simul();
        test_wrap();
        test_rst_deb();
        checks++;
        if (exp_q.size() != 0 || exp_qs.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d/%0d updates never seen, want 0/0",
                     exp_q.size(), exp_qs.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_select_gen.md
Name: freq_select_gen

Overview:
Parametrised, fully synchronous successor of the button-driven frequency selector. Debounces active-low up/down select buttons and steps through a table of NUM_MODES output frequencies, with wrap or saturate at the ends. Each mode maps to a half-period divider count, count = CLK_HZ/(2*f). The new count is applied only at a waveform period boundary, so the downstream DAC waveform generator never sees a mid-period change.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz; used in count computation.
NUM_MODES, 8, number of table entries (2..16).
CNT_W, 28, width of count output.
DEBOUNCE_CYC, 500_000, stable-level cycles needed to accept a button edge (10 ms).
WRAP, 1, 1 = wrap at the table ends; 0 = saturate at the table ends.
INIT_MODE, 0, mode loaded at reset.
MODE_W, derived localparam, $clog2(NUM_MODES).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sel_up_n  in  1  raw up button, active-low, asynchronous to clk
sel_dn_n  in  1  raw down button, active-low, asynchronous to clk
period_done  in  1  single-cycle pulse from the waveform generator at the end of each period
mode  out  MODE_W  currently requested mode index
count  out  CNT_W  applied half-period divider count
count_upd  out  1  one-cycle pulse in the cycle count takes a new value
pending  out  1  mode has changed; count not yet applied

Behaviour:
- Reset values, synchronous on rst=1: mode=INIT_MODE, count=table(INIT_MODE), pending=0, count_upd=0. Debouncers return to IDLE with their counters cleared.
- Input synchronisation: each button passes a 2-flop synchroniser before its debouncer.
- Debouncer FSM, one per button. States: IDLE (released), DEB_PRESS, HELD, DEB_REL.
  - IDLE -> DEB_PRESS on low level.
  - In DEB_PRESS, the counter increments each cycle the level stays low. A high level returns the FSM to IDLE with the counter cleared.
  - When the counter reaches DEBOUNCE_CYC-1, the FSM enters HELD and emits a one-cycle press event.
  - HELD -> DEB_REL on high level.
  - DEB_REL mirrors DEB_PRESS: it returns to IDLE after DEBOUNCE_CYC stable-high cycles, or goes back to HELD on a low level.
  - A release emits no event.
- Mode stepping: mode updates on the cycle after the press event (event registered in cycle N, mode valid in cycle N+1).
  - Up at NUM_MODES-1: goes to 0 if WRAP=1, holds otherwise.
  - Down at 0: goes to NUM_MODES-1 if WRAP=1, holds otherwise.
  - Up and down events in the same cycle: both ignored, no change.
  - A saturated step (no mode change) does not set pending.
- Apply: any change of mode sets pending=1.
  - In a cycle with period_done=1 and pending=1, count loads table(mode) on the next edge, count_upd pulses, and pending clears.
  - If a press event coincides with that period_done, count loads the pre-step mode's value and pending stays 1 for the new mode.
  - period_done with pending=0 has no effect.
  - Several presses before period_done apply only the final mode.
- Arithmetic: table entries are computed at elaboration as CLK_HZ/(2*f) with integer truncation.
  - Any entry below 1 is clamped to 1.
  - An entry that overflows CNT_W is an elaboration error.

Optional Feature:
FREQSEL_AUTOREPEAT_EN
- Defined: a button held in HELD for 50*DEBOUNCE_CYC cycles emits one additional press event. It then emits a repeat every 10*DEBOUNCE_CYC cycles while held. A saturated end stops further changes.
- Undefined: exactly one event per press. The repeat counter is not synthesised.

Decomposition:
- Package freqsel_pkg:
  - Default frequency table: 1k, 5k, 10k, 50k, 100k, 500k, 1M, 2M Hz.
  - Function freq2count(clk_hz, f).
  - Debouncer state enum.
- Sub-module btn_debounce: contains the synchroniser, debouncer FSM, and optional auto-repeat, and outputs a press pulse. It is instantiated twice.

Test Plan:
Use DEBOUNCE_CYC=16 and default table/width parameters in simulation.
1. Reset -> mode=0, count=25000, pending=0, count_upd=0.
2. sel_up_n low for 20 cycles, then period_done -> mode=1, pending=1 until the pulse; count=5000 with a one-cycle count_upd.
3. Bounce: sel_up_n low 10 cycles, high 2, low 10 -> no press event and mode unchanged; held low to 16 stable cycles -> one event.
4. Wrap: at mode=7, press up (WRAP=1) -> mode=0 and count=25000 after period_done. Rerun with WRAP=0 -> mode stays 7, count=12, pending=0.
5. Three up presses with no period_done, then period_done together with a fourth press -> count loads the third-step value, count_upd pulses, pending stays 1; the next period_done loads the fourth.
6. Simultaneous up and down events -> no change. rst during DEB_PRESS -> no event fires and mode=INIT_MODE.
